// File: rtl/gcd_unit_if.sv
// Operand/result handshake bundle for gcd_unit: valid/ready in, valid/ready out.
interface gcd_unit_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd;
  logic             both_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, gcd, both_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, gcd, both_zero
  );
endinterface

// File: rtl/gcd_unit.sv
// Iterative GCD engine (IDLE/CALC/DONE) with valid/ready operand and result handshakes.
// Define GCD_STEIN_EN to build the binary (Stein) CALC datapath instead of repeated subtraction.
module gcd_unit #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  gcd_unit_if.slave io_bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_gcd;
  logic             r_bothZero;
  logic             r_inReady;
  logic             r_outValid;

  logic             w_accept;
  logic             w_aZero;
  logic             w_bZero;

  assign w_accept = io_bus.in_valid && r_inReady;
  assign w_aZero  = (io_bus.a == '0);
  assign w_bZero  = (io_bus.b == '0);

  assign io_bus.in_ready  = r_inReady;
  assign io_bus.out_valid = r_outValid;
  assign io_bus.gcd       = r_gcd;
  assign io_bus.both_zero = r_bothZero;

`ifdef GCD_STEIN_EN
  localparam int KW = $clog2(WIDTH) + 1;

  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] w_halfDiff;

  assign w_halfDiff = ((r_p > r_q) ? (r_p - r_q) : (r_q - r_p)) >> 1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_p        <= '0;
      r_q        <= '0;
      r_gcd      <= '0;
      r_bothZero <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
`ifdef GCD_STEIN_EN
      r_k        <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_p       <= io_bus.a;
            r_q       <= io_bus.b;
            r_inReady <= 1'b0;
`ifdef GCD_STEIN_EN
            r_k       <= '0;
`endif
            // A zero operand makes the answer the other operand, so CALC is skipped.
            if (w_aZero || w_bZero) begin
              r_gcd      <= io_bus.a | io_bus.b;
              r_bothZero <= w_aZero && w_bZero;
              r_outValid <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end

        CALC: begin
          if (r_p == r_q) begin
`ifdef GCD_STEIN_EN
            r_gcd <= r_p << r_k;
`else
            r_gcd <= r_p;
`endif
            r_bothZero <= 1'b0;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
`ifdef GCD_STEIN_EN
            // Once one operand is odd, reduction keeps one odd, so stripping never resumes.
            if (!r_p[0] && !r_q[0]) begin
              r_p <= r_p >> 1;
              r_q <= r_q >> 1;
              r_k <= r_k + 1'b1;
            end else if (!r_p[0]) begin
              r_p <= r_p >> 1;
            end else if (!r_q[0]) begin
              r_q <= r_q >> 1;
            end else if (r_p > r_q) begin
              r_p <= w_halfDiff;
            end else begin
              r_q <= w_halfDiff;
            end
`else
            if (r_p > r_q) begin
              r_p <= r_p - r_q;
            end else begin
              r_q <= r_q - r_p;
            end
`endif
          end
        end

        DONE: begin
          if (io_bus.out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_unit.sv
// Directed bench for gcd_unit: an 8-bit instance for function/handshake scenarios and a 16-bit one for boundaries.
module tb_gcd_unit;

  localparam int TIMEOUT = 70000;

  logic clk = 1'b0;
  logic rst8;
  logic rst16;
  int   nChecks = 0;
  int   nFails  = 0;

  gcd_unit_if #(.WIDTH(8))  bus8 ();
  gcd_unit_if #(.WIDTH(16)) bus16 ();

  gcd_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .io_bus(bus8));
  gcd_unit #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst16), .io_bus(bus16));

  always #5 clk = ~clk;

  // Subtractive builds must hit the exact edge count; Stein builds only the bound (bypass stays exact).
  function automatic bit latOk(input int e, input int expEdges, input int w);
`ifdef GCD_STEIN_EN
    if (expEdges == 0) return (e == 0);
    return (e >= 1) && (e <= 2 * w + 2);
`else
    return (e == expEdges);
`endif
  endfunction

  function automatic int refGcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Called #1 after an edge with in_ready high; returns edges after the accept edge until out_valid, or -1.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int edges);
    bus8.a = a;
    bus8.b = b;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    edges = 0;
    while (!bus8.out_valid && edges < TIMEOUT) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!bus8.out_valid) edges = -1;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, output int edges);
    bus16.a = a;
    bus16.b = b;
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    edges = 0;
    while (!bus16.out_valid && edges < TIMEOUT) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!bus16.out_valid) edges = -1;
  endtask

  task automatic test_reset();
    int e;
    #2;
    nChecks++; if (bus8.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus8.in_ready); end
    nChecks++; if (bus8.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus8.out_valid); end
    nChecks++; if (bus8.gcd !== 8'd0) begin nFails++; $display("[TB] FAIL reset_gcd: got %0d expected 0", bus8.gcd); end
    nChecks++; if (bus8.both_zero !== 1'b0) begin nFails++; $display("[TB] FAIL reset_both_zero: got %b expected 0", bus8.both_zero); end
    nChecks++; if (bus16.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset16_in_ready: got %b expected 1", bus16.in_ready); end
    @(posedge clk); #1;
    rst8  = 1'b0;
    rst16 = 1'b0;
    @(posedge clk); #1;
    bus8.a = 8'd255;
    bus8.b = 8'd1;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst8 = 1'b1;
    #1;
    nChecks++; if (bus8.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL abort_out_valid: got %b expected 0", bus8.out_valid); end
    nChecks++; if (bus8.gcd !== 8'd0) begin nFails++; $display("[TB] FAIL abort_gcd: got %0d expected 0", bus8.gcd); end
    nChecks++; if (bus8.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL abort_in_ready: got %b expected 1", bus8.in_ready); end
    @(posedge clk); #1;
    rst8 = 1'b0;
    @(posedge clk); #1;
    run8(8'd12, 8'd12, e);
    nChecks++; if (bus8.gcd !== 8'd12) begin nFails++; $display("[TB] FAIL after_reset_gcd: got %0d expected 12", bus8.gcd); end
    nChecks++; if (!latOk(e, 1, 8)) begin nFails++; $display("[TB] FAIL after_reset_latency: got %0d expected 1", e); end
    @(posedge clk); #1;
  endtask

  task automatic test_subtractive();
    int e;
    run8(8'd48, 8'd18, e);
    nChecks++; if (bus8.gcd !== 8'd6) begin nFails++; $display("[TB] FAIL gcd_48_18: got %0d expected 6", bus8.gcd); end
    nChecks++; if (!latOk(e, 5, 8)) begin nFails++; $display("[TB] FAIL lat_48_18: got %0d expected 5", e); end
    nChecks++; if (bus8.both_zero !== 1'b0) begin nFails++; $display("[TB] FAIL bz_48_18: got %b expected 0", bus8.both_zero); end
    nChecks++; if (bus8.in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL ready_in_done: got %b expected 0", bus8.in_ready); end
    @(posedge clk); #1;
    nChecks++; if (bus8.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL valid_after_hs: got %b expected 0", bus8.out_valid); end
    nChecks++; if (bus8.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL ready_after_hs: got %b expected 1", bus8.in_ready); end
  endtask

  task automatic test_zero_bypass();
    int e;
    run8(8'd0, 8'd35, e);
    nChecks++; if (bus8.gcd !== 8'd35) begin nFails++; $display("[TB] FAIL gcd_0_35: got %0d expected 35", bus8.gcd); end
    nChecks++; if (bus8.both_zero !== 1'b0) begin nFails++; $display("[TB] FAIL bz_0_35: got %b expected 0", bus8.both_zero); end
    nChecks++; if (e !== 0) begin nFails++; $display("[TB] FAIL lat_0_35: got %0d expected 0", e); end
    @(posedge clk); #1;
    run8(8'd0, 8'd0, e);
    nChecks++; if (bus8.gcd !== 8'd0) begin nFails++; $display("[TB] FAIL gcd_0_0: got %0d expected 0", bus8.gcd); end
    nChecks++; if (bus8.both_zero !== 1'b1) begin nFails++; $display("[TB] FAIL bz_0_0: got %b expected 1", bus8.both_zero); end
    nChecks++; if (e !== 0) begin nFails++; $display("[TB] FAIL lat_0_0: got %0d expected 0", e); end
    @(posedge clk); #1;
    run8(8'd21, 8'd0, e);
    nChecks++; if (bus8.gcd !== 8'd21) begin nFails++; $display("[TB] FAIL gcd_21_0: got %0d expected 21", bus8.gcd); end
    nChecks++; if (bus8.both_zero !== 1'b0) begin nFails++; $display("[TB] FAIL bz_21_0: got %b expected 0", bus8.both_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int e;
    run8(8'd7, 8'd5, e);
    nChecks++; if (bus8.gcd !== 8'd1) begin nFails++; $display("[TB] FAIL gcd_7_5: got %0d expected 1", bus8.gcd); end
    nChecks++; if (!latOk(e, 5, 8)) begin nFails++; $display("[TB] FAIL lat_7_5: got %0d expected 5", e); end
    bus8.a = 8'd9;
    bus8.b = 8'd6;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    nChecks++; if (bus8.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL no_accept_on_hs: got in_ready %b expected 1", bus8.in_ready); end
    nChecks++; if (bus8.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL valid_on_hs: got %b expected 0", bus8.out_valid); end
    run8(8'd9, 8'd6, e);
    nChecks++; if (bus8.gcd !== 8'd3) begin nFails++; $display("[TB] FAIL gcd_9_6: got %0d expected 3", bus8.gcd); end
    nChecks++; if (!latOk(e, 3, 8)) begin nFails++; $display("[TB] FAIL lat_9_6: got %0d expected 3", e); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_pressure();
    int e;
    bus8.out_ready = 1'b0;
    run8(8'd100, 8'd75, e);
    nChecks++; if (!latOk(e, 4, 8)) begin nFails++; $display("[TB] FAIL lat_100_75: got %0d expected 4", e); end
    for (int i = 0; i < 10; i++) begin
      bus8.a = 8'd9;
      bus8.b = 8'd3;
      bus8.in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      nChecks++; if (bus8.out_valid !== 1'b1) begin nFails++; $display("[TB] FAIL bp_valid cycle %0d: got %b expected 1", i, bus8.out_valid); end
      nChecks++; if (bus8.gcd !== 8'd25) begin nFails++; $display("[TB] FAIL bp_gcd cycle %0d: got %0d expected 25", i, bus8.gcd); end
      nChecks++; if (bus8.in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL bp_in_ready cycle %0d: got %b expected 0", i, bus8.in_ready); end
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    nChecks++; if (bus8.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL bp_release_valid: got %b expected 0", bus8.out_valid); end
    nChecks++; if (bus8.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL bp_release_ready: got %b expected 1", bus8.in_ready); end
    nChecks++; if (bus8.gcd !== 8'd25) begin nFails++; $display("[TB] FAIL bp_gcd_kept: got %0d expected 25", bus8.gcd); end
  endtask

  task automatic test_boundary16();
    int e;
    run16(16'd65535, 16'd1, e);
    nChecks++; if (bus16.gcd !== 16'd1) begin nFails++; $display("[TB] FAIL gcd_65535_1: got %0d expected 1", bus16.gcd); end
    nChecks++; if (!latOk(e, 65535, 16)) begin nFails++; $display("[TB] FAIL lat_65535_1: got %0d expected 65535", e); end
    @(posedge clk); #1;
    run16(16'd65535, 16'd65535, e);
    nChecks++; if (bus16.gcd !== 16'd65535) begin nFails++; $display("[TB] FAIL gcd_65535_65535: got %0d expected 65535", bus16.gcd); end
    nChecks++; if (!latOk(e, 1, 16)) begin nFails++; $display("[TB] FAIL lat_65535_65535: got %0d expected 1", e); end
    @(posedge clk); #1;
    run16(16'd40960, 16'd1024, e);
    nChecks++; if (bus16.gcd !== 16'd1024) begin nFails++; $display("[TB] FAIL gcd_40960_1024: got %0d expected 1024", bus16.gcd); end
    nChecks++; if (!latOk(e, 40, 16)) begin nFails++; $display("[TB] FAIL lat_40960_1024: got %0d expected 40", e); end
    @(posedge clk); #1;
    run16(16'd1024, 16'd40960, e);
    nChecks++; if (bus16.gcd !== 16'd1024) begin nFails++; $display("[TB] FAIL gcd_1024_40960: got %0d expected 1024", bus16.gcd); end
    nChecks++; if (!latOk(e, 40, 16)) begin nFails++; $display("[TB] FAIL lat_1024_40960: got %0d expected 40", e); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int e;
    int expG;
    logic [7:0] x;
    logic [7:0] y;
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom_range(1, 255));
      y = 8'($urandom_range(1, 255));
      expG = refGcd(int'(x), int'(y));
      run8(x, y, e);
      nChecks++; if (int'(bus8.gcd) !== expG) begin nFails++; $display("[TB] FAIL rand_gcd(%0d,%0d): got %0d expected %0d", x, y, bus8.gcd, expG); end
      nChecks++; if (e < 1 || e > 255) begin nFails++; $display("[TB] FAIL rand_lat(%0d,%0d): got %0d expected 1..255", x, y, e); end
`ifdef GCD_STEIN_EN
      nChecks++; if (e > 18) begin nFails++; $display("[TB] FAIL rand_stein_lat(%0d,%0d): got %0d expected <=18", x, y, e); end
`endif
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst8  = 1'b1;
    rst16 = 1'b1;
    bus8.in_valid   = 1'b0;
    bus8.a          = '0;
    bus8.b          = '0;
    bus8.out_ready  = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.out_ready = 1'b1;
    $display("[TB] starting gcd_unit bench");
    test_reset();
    test_subtractive();
    test_zero_bypass();
    test_back_to_back();
    test_back_pressure();
    test_random();
    test_boundary16();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
